// File: rtl/motor_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : motor_pkg                                             |
// | Purpose  : Shared types and constants for the motor sequencer:   |
// |            FSM states, duty targets, L298 pin encodings and a    |
// |            one-step ramp helper.                                 |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package motor_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    STOP  = 3'd2,
    DEAD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [6:0] DUTY_100 = 7'd100;
  localparam logic [6:0] DUTY_75  = 7'd75;
  localparam logic [6:0] DUTY_50  = 7'd50;
  localparam logic [6:0] DUTY_25  = 7'd25;
  localparam logic [6:0] DUTY_0   = 7'd0;

  // Direction flag: 0 = forward, 1 = reverse
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Pin vectors ordered {in1_a, in2_a, in1_b, in2_b}
  localparam logic [3:0] PINS_FWD   = 4'b1001;
  localparam logic [3:0] PINS_REV   = 4'b0110;
  localparam logic [3:0] PINS_COAST = 4'b0000;

  // Move the duty one unit toward the target; targets never exceed 100,
  // so the result stays inside 0..100.
  function automatic logic [6:0] ramp_step(input logic [6:0] cur, input logic [6:0] tgt);
    if (cur < tgt)      return cur + 7'd1;
    else if (cur > tgt) return cur - 7'd1;
    else                return cur;
  endfunction

endpackage : motor_pkg
`default_nettype wire

// File: rtl/oc_filter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : oc_filter                                             |
// | Purpose  : Consecutive-sample glitch filter for one overcurrent  |
// |            sense input. Raises trip once OC_FILTER highs in a    |
// |            row have been seen.                                   |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module oc_filter #(
  parameter int OC_FILTER = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic oc_in,
  output logic trip
);

  localparam int CW = $clog2(OC_FILTER + 1);

  logic [CW-1:0] cnt;

  // Count consecutive high samples, clear on any low, saturate at OC_FILTER
  always_ff @(posedge clk) begin
    if (rst)                         cnt <= '0;
    else if (!oc_in)                 cnt <= '0;
    else if (cnt != CW'(OC_FILTER))  cnt <= cnt + CW'(1);
  end

  // Look-ahead: trip is high in the cycle whose edge registers the
  // OC_FILTER-th high, so the sequencer can enter FAULT on that same edge.
  assign trip = oc_in && (cnt >= CW'(OC_FILTER - 1));

endmodule : oc_filter
`default_nettype wire

// File: rtl/motor_drive_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : motor_drive_sequencer                                 |
// | Purpose  : Switch-to-PWM command sequencer with duty ramping,    |
// |            reversal dead time and latched overcurrent fault.     |
// | Options  : MOTOR_AUTO_RETRY_EN - timed fault auto-retry; when    |
// |            undefined the fault clears on sw==0 with no trip.     |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module motor_drive_sequencer
  import motor_pkg::*;
#(
  parameter int RAMP_DIV     = 100000,
  parameter int DEADTIME_CYC = 1000000,
  parameter int OC_FILTER    = 9,
  parameter int RETRY_CYC    = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       oc_a,
  input  logic       oc_b,
  output logic [6:0] duty,
  output logic       in1_a,
  output logic       in2_a,
  output logic       in1_b,
  output logic       in2_b,
  output logic       fault,
  output logic [2:0] state
);

  localparam int PW = $clog2(RAMP_DIV + 1);
  localparam int DW = $clog2(DEADTIME_CYC + 1);

  logic          trip_a, trip_b, trip_any;
  logic [6:0]    req_duty;
  logic          req_dir;
  logic [PW-1:0] presc;
  logic          tick;

  state_t        state_q, state_d;
  logic [6:0]    duty_q, duty_d;
  logic          dir_cur, dir_d;
  logic [DW-1:0] dead_cnt, dead_d;
  logic [3:0]    pins_q, pins_d;
  logic          fault_q;

`ifdef MOTOR_AUTO_RETRY_EN
  localparam int RW = $clog2(RETRY_CYC + 1);
  logic [RW-1:0] retry_cnt, retry_d;
`endif

  oc_filter #(.OC_FILTER(OC_FILTER)) u_oc_a (.clk(clk), .rst(rst), .oc_in(oc_a), .trip(trip_a));
  oc_filter #(.OC_FILTER(OC_FILTER)) u_oc_b (.clk(clk), .rst(rst), .oc_in(oc_b), .trip(trip_b));

  assign trip_any = trip_a | trip_b;

  // Resolve switches: lowest asserted index wins
  always_comb begin
    req_duty = DUTY_0;
    req_dir  = DIR_FWD;
    if      (sw[0]) begin req_duty = DUTY_100; req_dir = DIR_FWD; end
    else if (sw[1]) begin req_duty = DUTY_75;  req_dir = DIR_FWD; end
    else if (sw[2]) begin req_duty = DUTY_50;  req_dir = DIR_FWD; end
    else if (sw[3]) begin req_duty = DUTY_25;  req_dir = DIR_FWD; end
    else if (sw[4]) begin req_duty = DUTY_100; req_dir = DIR_REV; end
    else if (sw[5]) begin req_duty = DUTY_75;  req_dir = DIR_REV; end
    else if (sw[6]) begin req_duty = DUTY_50;  req_dir = DIR_REV; end
    else if (sw[7]) begin req_duty = DUTY_25;  req_dir = DIR_REV; end
  end

  // Free-running ramp prescaler
  always_ff @(posedge clk) begin
    if (rst || tick) presc <= '0;
    else             presc <= presc + PW'(1);
  end

  assign tick = (presc == PW'(RAMP_DIV - 1));

  // Next-state, duty and counter logic; a trip overrides everything
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_cur;
    dead_d  = '0;
`ifdef MOTOR_AUTO_RETRY_EN
    retry_d = '0;
`endif
    case (state_q)
      IDLE: begin
        duty_d = DUTY_0;
        if (req_duty != DUTY_0) begin
          dir_d   = req_dir;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (tick) duty_d = ramp_step(duty_q, (req_dir == dir_cur) ? req_duty : DUTY_0);
        if (req_duty != DUTY_0 && req_dir != dir_cur) state_d = STOP;
        else if (req_duty == DUTY_0 && duty_q == DUTY_0) state_d = IDLE;
      end
      STOP: begin
        if (tick) duty_d = ramp_step(duty_q, DUTY_0);
        if (duty_q == DUTY_0) state_d = DEAD;
      end
      DEAD: begin
        duty_d = DUTY_0;
        if (dead_cnt == DW'(DEADTIME_CYC - 1)) begin
          if (req_duty != DUTY_0) begin
            dir_d   = req_dir;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dead_d = dead_cnt + DW'(1);
        end
      end
      FAULT: begin
        duty_d = DUTY_0;
`ifdef MOTOR_AUTO_RETRY_EN
        if (retry_cnt == RW'(RETRY_CYC - 1)) state_d = IDLE;
        else                                 retry_d = retry_cnt + RW'(1);
`else
        if (sw == 8'd0) state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
        duty_d  = DUTY_0;
      end
    endcase
    if (trip_any) begin
      state_d = FAULT;
      duty_d  = DUTY_0;
      dead_d  = '0;
`ifdef MOTOR_AUTO_RETRY_EN
      retry_d = '0;
`endif
    end
  end

  // Pins are decoded from the next state so they change on the same edge as state
  always_comb begin
    pins_d = PINS_COAST;
    if (state_d == DRIVE || state_d == STOP) pins_d = (dir_d == DIR_REV) ? PINS_REV : PINS_FWD;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      duty_q   <= DUTY_0;
      dir_cur  <= DIR_FWD;
      dead_cnt <= '0;
      pins_q   <= PINS_COAST;
      fault_q  <= 1'b0;
`ifdef MOTOR_AUTO_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      dir_cur  <= dir_d;
      dead_cnt <= dead_d;
      pins_q   <= pins_d;
      fault_q  <= (state_d == FAULT);
`ifdef MOTOR_AUTO_RETRY_EN
      retry_cnt <= retry_d;
`endif
    end
  end

  assign duty  = duty_q;
  assign in1_a = pins_q[3];
  assign in2_a = pins_q[2];
  assign in1_b = pins_q[1];
  assign in2_b = pins_q[0];
  assign fault = fault_q;
  assign state = state_q;

endmodule : motor_drive_sequencer
`default_nettype wire

// File: tb/tb_motor_drive_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_motor_drive_sequencer                              |
// | Purpose  : Self-checking bench for motor_drive_sequencer with    |
// |            short ramp/dead/retry timing and a scoreboard queue.  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_motor_drive_sequencer;
  import motor_pkg::*;

  localparam int RAMP_DIV     = 4;
  localparam int DEADTIME_CYC = 8;
  localparam int OC_FILTER    = 9;
  localparam int RETRY_CYC    = 32;

  localparam int P_FWD   = 9;  // 4'b1001
  localparam int P_REV   = 6;  // 4'b0110
  localparam int P_COAST = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       oc_a, oc_b;
  logic [6:0] duty;
  logic       in1_a, in2_a, in1_b, in2_b;
  logic       fault;
  logic [2:0] state;

  motor_drive_sequencer #(
    .RAMP_DIV(RAMP_DIV), .DEADTIME_CYC(DEADTIME_CYC),
    .OC_FILTER(OC_FILTER), .RETRY_CYC(RETRY_CYC)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .oc_a(oc_a), .oc_b(oc_b),
    .duty(duty), .in1_a(in1_a), .in2_a(in2_a), .in1_b(in1_b), .in2_b(in2_b),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_viol = 0;
  int   prev_duty = 0;
  logic rst_at_edge;

  // Watch every cycle: duty may rise by at most 1, and may fall by more
  // than 1 only on reset or fault entry; it must never exceed 100.
  always @(posedge clk) begin
    rst_at_edge = rst;
    #1;
    if (int'(duty) > prev_duty + 1 || int'(duty) > 100) step_viol++;
    if (int'(duty) < prev_duty - 1 && !fault && !rst_at_edge) step_viol++;
    prev_duty = int'(duty);
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int obs);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("scoreboard_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  function automatic int pins_now();
    return int'({in1_a, in2_a, in1_b, in2_b});
  endfunction

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_duty(input int tgt, input int budget, output int n);
    n = 0;
    while (int'(duty) != tgt && n < budget) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_state(input int st, input int budget);
    int n = 0;
    while (int'(state) != st && n < budget) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    int n;
    int nd;
    rst = 1'b1; sw = 8'h00; oc_a = 1'b0; oc_b = 1'b0;
    step(3);

    // Reset state
    push("rst_duty", 0); push("rst_pins", P_COAST); push("rst_fault", 0); push("rst_state", int'(IDLE));
    pop_check(int'(duty)); pop_check(pins_now()); pop_check(int'(fault)); pop_check(int'(state));
    rst = 1'b0;
    step(2);
    push("idle_hold", int'(IDLE)); pop_check(int'(state));

    // Ramp up to 100 forward
    sw = 8'h01;
    push("up_state", int'(DRIVE)); push("up_pins", P_FWD);
    step(1);
    pop_check(int'(state)); pop_check(pins_now());
    push("up_duty", 100); push("up_time_ok", 1);
    wait_duty(100, 600, n);
    pop_check(int'(duty)); pop_check(int'(n >= 396 && n <= 401));
    push("up_hold", 100);
    step(20);
    pop_check(int'(duty));

    // Priority: sw[1] beats sw[3]
    sw = 8'h0A;
    push("pri_state", int'(DRIVE));
    step(1);
    pop_check(int'(state));
    push("pri_duty", 75);
    wait_duty(75, 200, n);
    pop_check(int'(duty));
    step(12);
    push("pri_hold", 75); push("pri_pins", P_FWD);
    pop_check(int'(duty)); pop_check(pins_now());

    // Reversal from 50 forward
    sw = 8'h04;
    push("rev_start_duty", 50);
    wait_duty(50, 200, n);
    pop_check(int'(duty));
    sw = 8'h40;
    push("rev_stop_state", int'(STOP)); push("rev_stop_pins", P_FWD);
    step(1);
    pop_check(int'(state)); pop_check(pins_now());
    push("rev_dead_state", int'(DEAD)); push("rev_dead_duty", 0); push("rev_dead_pins", P_COAST);
    wait_state(int'(DEAD), 300);
    pop_check(int'(state)); pop_check(int'(duty)); pop_check(pins_now());
    nd = 0;
    while (int'(state) == int'(DEAD) && nd < 30) begin
      nd++;
      step(1);
    end
    push("rev_dead_len", DEADTIME_CYC); push("rev_drive_state", int'(DRIVE)); push("rev_drive_pins", P_REV);
    pop_check(nd); pop_check(int'(state)); pop_check(pins_now());
    push("rev_end_duty", 50);
    wait_duty(50, 300, n);
    pop_check(int'(duty));

    // Overcurrent: 8 highs are filtered out
    oc_a = 1'b1;
    step(8);
    oc_a = 1'b0;
    step(1);
    push("oc8_fault", 0); push("oc8_state", int'(DRIVE));
    pop_check(int'(fault)); pop_check(int'(state));

    // Overcurrent: 9th consecutive high trips on that edge
    oc_a = 1'b1;
    step(8);
    push("oc9_pre", 0);
    pop_check(int'(fault));
    step(1);
    push("oc9_fault", 1); push("oc9_duty", 0); push("oc9_pins", P_COAST); push("oc9_state", int'(FAULT));
    pop_check(int'(fault)); pop_check(int'(duty)); pop_check(pins_now()); pop_check(int'(state));
    oc_a = 1'b0;

    // Fault exit
`ifdef MOTOR_AUTO_RETRY_EN
    step(RETRY_CYC - 1);
    push("retry_hold", 1);
    pop_check(int'(fault));
    step(1);
    sw = 8'h00;
    push("retry_clear", 0); push("retry_state", int'(IDLE));
    pop_check(int'(fault)); pop_check(int'(state));
`else
    step(40);
    push("latch_hold", 1);
    pop_check(int'(fault));
    sw = 8'h00;
    step(1);
    push("latch_clear", 0); push("latch_state", int'(IDLE));
    pop_check(int'(fault)); pop_check(int'(state));
`endif
    step(2);

    // Channel B trips too
    sw = 8'h01;
    step(5);
    oc_b = 1'b1;
    step(OC_FILTER);
    push("ocb_fault", 1); push("ocb_state", int'(FAULT));
    pop_check(int'(fault)); pop_check(int'(state));
    oc_b = 1'b0;
    sw = 8'h00;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    push("ocb_rst_state", int'(IDLE)); push("ocb_rst_fault", 0);
    pop_check(int'(state)); pop_check(int'(fault));

    // Reset mid-ramp at duty 60
    sw = 8'h01;
    push("mid_duty60", 60);
    wait_duty(60, 400, n);
    pop_check(int'(duty));
    rst = 1'b1;
    step(1);
    push("mid_rst_duty", 0); push("mid_rst_state", int'(IDLE)); push("mid_rst_pins", P_COAST); push("mid_rst_fault", 0);
    pop_check(int'(duty)); pop_check(int'(state)); pop_check(pins_now()); pop_check(int'(fault));
    rst = 1'b0;
    sw = 8'h00;
    step(2);

    push("ramp_step_viol", 0);
    pop_check(step_viol);
    check_eq("sb_leftover", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case a wait loop misbehaves
  initial begin
    #200000;
    $display("FAIL global_timeout: observed %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule : tb_motor_drive_sequencer
`default_nettype wire

// File: doc/motor_drive_sequencer.md
# motor_drive_sequencer

Command sequencer between the Basys 3 switch bank and the PWM generator and L298 bridge on PMOD JC. It resolves the eight speed/direction switches into one request and ramps duty toward it, so speed changes are never steps. Every reversal passes through a ramp-down and a coast dead time. Filtered overcurrent inputs latch a fault that forces the bridge off. Outputs drive the PWM compare value and both motors' direction pins.

## Interface
- RAMP_DIV, 100000: clocks per 1 % duty step (1 ms at 100 MHz).
- DEADTIME_CYC, 1000000: coast cycles at zero duty before a direction change (10 ms).
- OC_FILTER, 9: consecutive high samples of an overcurrent input that trip a fault.
- RETRY_CYC, 50000000: fault hold time before auto-retry (0.5 s); used only with the retry macro.
- clk, input, 1: 100 MHz system clock.
- rst, input, 1: synchronous, active-high reset.
- sw, input, 8: switch requests. sw[0..3] are forward at 100/75/50/25 %. sw[4..7] are reverse at the same duties.
- oc_a, oc_b, input, 1 each: overcurrent sense for motor A and motor B, active high.
- duty, output, 7: PWM compare value, 0..100.
- in1_a, in2_a, in1_b, in2_b, output, 1 each: L298 direction pins.
- fault, output, 1: overcurrent fault latched.
- state, output, 3: current FSM state, for debug LEDs.

## Operation
- Request decode:
  - The lowest-index asserted switch wins, so sw[0] has top priority.
  - It sets the request target (req_duty) and request direction (req_dir).
  - No switch asserted gives req_duty=0, and req_dir is ignored.
- Ramp tick:
  - A free-running prescaler counts 0..RAMP_DIV-1.
  - The tick is asserted in the cycle the count equals RAMP_DIV-1.
  - On a tick, duty moves exactly 1 toward the active target.
  - duty never exceeds 100 and never goes below 0.
- Direction pin encoding:
  - Forward: in1_a=1, in2_a=0, in1_b=0, in2_b=1.
  - Reverse: all four pins inverted.
  - Coast: all four pins 0.
- States:
  - IDLE: duty=0, pins coast. When req_duty>0, latch dir_cur=req_dir and go to DRIVE.
  - DRIVE: pins follow dir_cur.
    - If req_duty>0 and req_dir==dir_cur, ramp toward req_duty.
    - If req_duty==0, ramp toward 0, then go to IDLE when duty==0.
    - If req_duty>0 and req_dir!=dir_cur, go to STOP.
  - STOP: pins keep dir_cur. Ramp toward 0, then go to DEAD when duty==0.
  - DEAD: duty=0, pins coast, count DEADTIME_CYC cycles.
    - At expiry with req_duty>0, latch dir_cur=req_dir and go to DRIVE.
    - At expiry with req_duty==0, go to IDLE.
  - FAULT: duty=0, pins coast, fault=1. Exit depends on MOTOR_AUTO_RETRY_EN.
- Overcurrent filter, one per channel:
  - The counter increments while the input is 1, clears while it is 0, and saturates at OC_FILTER.
  - Reaching OC_FILTER raises that channel's trip.
- Priority:
  - A trip from either channel forces FAULT from any state, overriding every other transition in the same cycle.
  - Any trip while already in FAULT restarts the retry count.
- A request change within the same direction during DRIVE only retargets the ramp. There is no state change.
- A reversal request withdrawn during STOP or DEAD completes that sequence anyway.
- Reset mid-operation: all state, counters and outputs clear on the next edge. There is no ramp-down.

## Timing
- All outputs are registered.
- Reset values: duty=0, all pins 0, fault=0, state=IDLE. The prescaler, DEAD counter and OC counters are 0.
- A switch change is reflected in state one edge after it is sampled.
- The first duty step occurs on the next tick, up to RAMP_DIV cycles later.
- A full 0→100 ramp takes 100 ticks.
- Fault latency: fault=1, duty=0 and pins coast on the same edge that samples the OC_FILTER-th consecutive high.
- Reversal from duty D takes D ticks of ramp-down, then DEADTIME_CYC cycles of coast, then DRIVE in the new direction.

## Configuration
- MOTOR_AUTO_RETRY_EN defined:
  - FAULT counts RETRY_CYC cycles with both trips clear, then goes to IDLE.
  - The motor restarts from duty 0 under the ramp.
- MOTOR_AUTO_RETRY_EN not defined:
  - FAULT is held until rst, or until a cycle with sw==0 and both trips clear. It then goes to IDLE.
  - RETRY_CYC is unused.

## Structure
- Package motor_pkg holds:
  - the FSM state enum;
  - the duty constants DUTY_100/75/50/25;
  - the forward, reverse and coast pin encodings.
- Sub-module oc_filter (parameter OC_FILTER, ports clk, rst, oc_in, trip) is instantiated once per channel.

## Test plan
Bench parameters: RAMP_DIV=4, DEADTIME_CYC=8, OC_FILTER=9, RETRY_CYC=32.
- Ramp up: sw=8'h01 from IDLE → DRIVE, forward pins, duty reaches 100 after 100 ticks (about 400 cycles), then holds.
- Priority: sw=8'h0A → target 75 forward, because sw[1] beats sw[3].
- Reversal: at duty 50 forward, sw=8'h40 → STOP ramps to 0, DEAD shows pins 0000 for 8 cycles, then DRIVE reverse ramps to 50.
- Overcurrent filtering:
  - oc_a high for 8 cycles then low → no fault.
  - oc_a high for 9 cycles → FAULT on the 9th edge, duty 0, pins 0000.
- Fault exit:
  - With the macro, fault clears 32 cycles after oc drops.
  - Without it, fault holds until sw=0 for one cycle.
- Reset mid-ramp: rst during DRIVE at duty 60 → next edge gives duty 0, IDLE, pins 0000.
